sprite_draw_scheduler: RTL and testbench
========================================

// Module: sprite_draw_scheduler
// PURPOSE
//  Shares the single vga_adapter plot port (x, y, colour, plot) between NUM_REQ sprite
//  drawers (enemy, left glove, player, right glove).
//  Grants one requester at a time, round-robin. Walks an SPR_W x SPR_H raster over the
//  shared sprite ROM address bus and plots each pixel at the requester's base x/y.
//  Replaces per-sprite start_next chaining. Sits between the game/init logic and vga_adapter.
// PARAMETERS
//  NUM_REQ        4       number of requesters
//  SPR_W          40      sprite width, pixels
//  SPR_H          40      sprite height, pixels
//  ROM_AW         11      sprite ROM address width; SPR_W*SPR_H must be <= 2**ROM_AW
//  TRANSPARENT_EN 0       1: pixels equal to TRANSP_COL are not plotted
//  TRANSP_COL     3'b000  transparent colour code
// PORTS
//  clock     in   1           system clock (CLOCK_50)
//  reset_n   in   1           asynchronous, active-low reset
//  req       in   NUM_REQ     level request; held by requester until its done pulse
//  base_x    in   NUM_REQ*8   packed sprite top-left x; slice i = [8*i+7:8*i]
//  base_y    in   NUM_REQ*7   packed sprite top-left y; slice i = [7*i+6:7*i]
//  grant     out  NUM_REQ     one-hot; high for the whole service of requester i
//  done      out  NUM_REQ     one-cycle pulse when requester i's sprite is fully plotted
//  busy      out  1           high in every state except IDLE
//  rom_addr  out  ROM_AW      pixel index row*SPR_W+col; ROM selected externally by grant
//  rom_q     in   3           colour from granted ROM; valid exactly 1 cycle after rom_addr
//  x         out  8           to vga_adapter.x
//  y         out  7           to vga_adapter.y
//  colour    out  3           to vga_adapter.colour
//  plot      out  1           to vga_adapter.plot
// BEHAVIOUR
//  Reset (async, reset_n=0):
//  - state=IDLE; grant, done, busy, plot, x, y, colour, rom_addr all 0.
//  - rr pointer = NUM_REQ-1, so req[0] wins first.
//  - A reset mid-draw abandons the sprite; no done pulse is issued.
//  FSM states: IDLE -> DRAW -> FLUSH -> FIN -> IDLE.
//  - IDLE:
//    - If req != 0, pick the first set bit searching upward from (ptr+1) mod NUM_REQ.
//    - Latch base_x/base_y of the winner; grant[w] <= 1; col=row=0.
//    - Next state DRAW. If req == 0, stay in IDLE.
//  - DRAW: one ROM address per cycle; rom_addr = row*SPR_W+col.
//    - col increments; on col==SPR_W-1, col wraps to 0 and row increments.
//    - After issuing (SPR_W-1, SPR_H-1), go to FLUSH.
//  - FLUSH: one cycle that lets the last ROM read return.
//  - FIN: done[w]=1 for this cycle only; grant <= 0; ptr <= w; next state IDLE.
//  Pixel pipeline (1 stage, matched to ROM latency):
//  - (valid, col, row) are registered alongside each address.
//  - In the following cycle: x = base_x+col, y = base_y+row, colour = rom_q.
//  - plot = valid & on_screen & ~(TRANSPARENT_EN & rom_q==TRANSP_COL).
//  - Address issue to plot: 1 cycle.
//  - Sprite service time: 1 (IDLE) + SPR_W*SPR_H + 1 (FLUSH) + 1 (FIN) cycles.
//  Width rules and clipping:
//  - Coordinate sums are computed in 9 bits (x) and 8 bits (y).
//  - on_screen = (sum_x < 160) & (sum_y < 120); off-screen pixels are still walked but never plotted.
//  - x and y carry the truncated sums.
//  Boundary conditions:
//  - req[w] drops mid-draw: the sprite still completes and done[w] still pulses.
//  - base_x/base_y changes mid-draw: ignored (latched in IDLE).
//  - req[w] still high after done: re-arbitrates in IDLE with w now lowest priority,
//    so w is re-granted only if no other request is pending.
//  - New req in the same cycle as FIN: seen in IDLE on the next cycle.
//  - grant stays one-hot or zero at all times; at most one done bit is high at a time.
// STRUCTURE
//  sprite_pkg (shared):
//  - SCREEN_W=160, SCREEN_H=120, COL_W=3, X_W=8, Y_W=7.
//  - State encoding localparams S_IDLE/S_DRAW/S_FLUSH/S_FIN.
//  Sub-module rr_pick:
//  - Combinational round-robin priority picker (req, ptr -> one-hot win, index, any).
//  - Reused by future audio/input arbiters.
// TESTING
//  - Reset, then req=4'b0001, base (12,6):
//    - grant=0001 for 1602 cycles.
//    - First plot at x=12, y=6 one cycle after rom_addr=0; last plot at (51,45), addr 1599.
//    - Then done=0001 for 1 cycle.
//  - req=4'b1111 held continuously:
//    - Grants in order 0,1,2,3,0; exactly one done per sprite; no overlap of grant bits.
//  - base (150,100), SPR 40x40:
//    - Only pixels with x<160, y<120 are plotted (10x20 = 200 plots).
//    - FIN still occurs at cycle 1602.
//  - TRANSPARENT_EN=1, ROM model returning 0 at every even address: exactly 800 plots.
//  - Pulse reset_n low at pixel 500 of sprite 2:
//    - All outputs are 0 immediately (async); no done pulse.
//    - After release, req[0] wins first.
//  - Drop req[1] mid-draw: sprite 1 completes and done[1] pulses; req[1] is not re-granted.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and state encoding for the sprite plotting path.
package sprite_pkg;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COL_W    = 3;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_DRAW  = 2'd1;
    localparam state_t S_FLUSH = 2'd2;
    localparam state_t S_FIN   = 2'd3;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request bit found searching
// upward from (ptr+1) mod N wins.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [PW-1:0] idx,
    output logic          any
);
    logic [PW-1:0] cand;

    // Scan farthest offset first so the nearest requester after ptr overrides.
    always_comb begin
        win  = '0;
        idx  = '0;
        cand = '0;
        for (int k = N; k >= 1; k--) begin
            cand = PW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                win       = '0;
                win[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

    assign any = |req;
endmodule

// File: rtl/sprite_draw_scheduler.sv
// Round-robin owner of the single vga_adapter plot port: grants one sprite
// drawer, walks its raster over the shared ROM bus and plots each pixel at
// the drawer's latched base position.
module sprite_draw_scheduler
    import sprite_pkg::*;
#(
    parameter int         NUM_REQ        = 4,
    parameter int         SPR_W          = 40,
    parameter int         SPR_H          = 40,
    parameter int         ROM_AW         = 11,
    parameter int         TRANSPARENT_EN = 0,
    parameter logic [2:0] TRANSP_COL     = 3'b000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*X_W-1:0] base_x,
    input  logic [NUM_REQ*Y_W-1:0] base_y,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic [ROM_AW-1:0]      rom_addr,
    input  logic [COL_W-1:0]       rom_q,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [COL_W-1:0]       colour,
    output logic                   plot
);
    localparam int PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW   = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int SX_W = X_W + 1;
    localparam int SY_W = Y_W + 1;

    state_t               state_reg, state_next;
    logic [PW-1:0]        ptr_reg, idx_reg;
    logic [NUM_REQ-1:0]   grant_reg;
    logic [X_W-1:0]       bx_reg;
    logic [Y_W-1:0]       by_reg;
    logic [CW-1:0]        col_reg, colp_reg;
    logic [RW-1:0]        row_reg, rowp_reg;
    logic                 vld_reg;

    logic [NUM_REQ-1:0]   pick_win;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;
    logic                 last_px;
    logic [SX_W-1:0]      sum_x;
    logic [SY_W-1:0]      sum_y;
    logic                 on_screen;
    logic                 transp;

    logic [X_W-1:0]       bx_arr [NUM_REQ];
    logic [Y_W-1:0]       by_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign bx_arr[gi] = base_x[gi*X_W +: X_W];
            assign by_arr[gi] = base_y[gi*Y_W +: Y_W];
        end
    endgenerate

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req (req),
        .ptr (ptr_reg),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign last_px = (col_reg == CW'(SPR_W - 1)) && (row_reg == RW'(SPR_H - 1));

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_reg <= S_IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic: IDLE -> DRAW -> FLUSH -> FIN -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (pick_any) state_next = S_DRAW;
            S_DRAW:  if (last_px)  state_next = S_FLUSH;
            S_FLUSH: state_next = S_FIN;
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs: busy, the done pulse and the ROM address.
    always_comb begin
        busy     = (state_reg != S_IDLE);
        done     = (state_reg == S_FIN) ? grant_reg : '0;
        rom_addr = '0;
        if (state_reg == S_DRAW)
            rom_addr = ROM_AW'(int'(row_reg) * SPR_W + int'(col_reg));
    end

    // Grant/base latch, raster counters and the one-stage pixel pipeline.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg   <= PW'(NUM_REQ - 1);
            idx_reg   <= '0;
            grant_reg <= '0;
            bx_reg    <= '0;
            by_reg    <= '0;
            col_reg   <= '0;
            row_reg   <= '0;
            vld_reg   <= 1'b0;
            colp_reg  <= '0;
            rowp_reg  <= '0;
        end else begin
            vld_reg  <= (state_reg == S_DRAW);
            colp_reg <= col_reg;
            rowp_reg <= row_reg;
            case (state_reg)
                S_IDLE: begin
                    if (pick_any) begin
                        grant_reg <= pick_win;
                        idx_reg   <= pick_idx;
                        bx_reg    <= bx_arr[pick_idx];
                        by_reg    <= by_arr[pick_idx];
                        col_reg   <= '0;
                        row_reg   <= '0;
                    end
                end
                S_DRAW: begin
                    if (col_reg == CW'(SPR_W - 1)) begin
                        col_reg <= '0;
                        row_reg <= row_reg + 1'b1;
                    end else begin
                        col_reg <= col_reg + 1'b1;
                    end
                end
                S_FIN: begin
                    grant_reg <= '0;
                    ptr_reg   <= idx_reg;
                end
                default: ;
            endcase
        end
    end

    assign grant = grant_reg;

    // Pixel stage: position from the delayed counters, colour straight from the ROM.
    always_comb begin
        sum_x     = SX_W'(bx_reg) + SX_W'(colp_reg);
        sum_y     = SY_W'(by_reg) + SY_W'(rowp_reg);
        on_screen = (sum_x < SX_W'(SCREEN_W)) && (sum_y < SY_W'(SCREEN_H));
        transp    = (TRANSPARENT_EN != 0) && (rom_q == TRANSP_COL);
        plot      = vld_reg && on_screen && !transp;
        x         = vld_reg ? sum_x[X_W-1:0] : '0;
        y         = vld_reg ? sum_y[Y_W-1:0] : '0;
        colour    = vld_reg ? rom_q : '0;
    end
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Bench for sprite_draw_scheduler: a cycle-indexed service model predicts every
// output each cycle; directed scenarios add literal expectations on top.
module tb_sprite_draw_scheduler;
    localparam int N    = 4;
    localparam int W    = 40;
    localparam int H    = 40;
    localparam int NPIX = W * H;
    localparam int SVC  = NPIX + 2;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req     = '0;
    logic [31:0] base_x  = '0;
    logic [27:0] base_y  = '0;

    logic [3:0]  grant0, done0, grant1, done1;
    logic        busy0, plot0, busy1, plot1;
    logic [10:0] rom_addr0, rom_addr1;
    logic [2:0]  rom_q0 = '0, rom_q1 = '0, colour0, colour1;
    logic [7:0]  x0, x1;
    logic [6:0]  y0, y1;

    sprite_draw_scheduler dut0 (
        .clock(clock), .reset_n(reset_n), .req(req), .base_x(base_x), .base_y(base_y),
        .grant(grant0), .done(done0), .busy(busy0), .rom_addr(rom_addr0), .rom_q(rom_q0),
        .x(x0), .y(y0), .colour(colour0), .plot(plot0)
    );

    sprite_draw_scheduler #(.TRANSPARENT_EN(1), .TRANSP_COL(3'b000)) dut1 (
        .clock(clock), .reset_n(reset_n), .req(req), .base_x(base_x), .base_y(base_y),
        .grant(grant1), .done(done1), .busy(busy1), .rom_addr(rom_addr1), .rom_q(rom_q1),
        .x(x1), .y(y1), .colour(colour1), .plot(plot1)
    );

    always #10 clock = ~clock;

    function automatic int rom0(input int a);
        return (a & 7) ^ ((a >> 3) & 7);
    endfunction

    // Synchronous ROM models, one cycle of latency.
    always @(posedge clock) begin
        rom_q0 <= 3'(rom0(int'(rom_addr0)));
        rom_q1 <= rom_addr1[0] ? 3'd5 : 3'd0;
    end

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- service model ----------------
    bit m_active = 1'b0;
    int m_t = 0, m_w = 0, m_ptr = N - 1, m_bx = 0, m_by = 0;
    int e_grant, e_done, e_busy, e_plot, e_addr, e_pix, p, sx, sy, c;
    bit found;

    // Compare process: predict every output from cycle position within a service.
    always @(negedge clock) begin
        if (!reset_n) begin
            m_active = 1'b0;
            m_ptr    = N - 1;
            chk("reset_outs", int'(|{grant0, done0, busy0, plot0, rom_addr0, x0, y0, colour0}), 0);
        end else begin
            e_grant = 0; e_done = 0; e_busy = 0; e_plot = 0; e_addr = 0; e_pix = 0;
            if (m_active) begin
                e_grant = 1 << m_w;
                e_busy  = 1;
                e_addr  = (m_t <= NPIX) ? m_t - 1 : 0;
                if (m_t >= 2 && m_t <= NPIX + 1) begin
                    p      = m_t - 2;
                    sx     = m_bx + p % W;
                    sy     = m_by + p / W;
                    e_plot = (sx < 160 && sy < 120) ? 1 : 0;
                    e_pix  = ((sx & 255) << 10) | ((sy & 127) << 3) | rom0(p);
                end
                e_done = (m_t == SVC) ? e_grant : 0;
            end
            chk("ctrl", int'({grant0, done0, busy0, plot0, rom_addr0}),
                (e_grant << 17) | (e_done << 13) | (e_busy << 12) | (e_plot << 11) | e_addr);
            chk("ctrl1", int'({grant1, done1, busy1, rom_addr1}),
                (e_grant << 16) | (e_done << 12) | (e_busy << 11) | e_addr);
            if (e_plot != 0)
                chk("pixel", int'({x0, y0, colour0}), e_pix);
            if (!m_active) begin
                found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_ptr + k) % N;
                    if (!found && req[c]) begin
                        found = 1'b1;
                        m_w   = c;
                    end
                end
                if (found) begin
                    m_active = 1'b1;
                    m_t      = 1;
                    m_bx     = int'((base_x >> (8 * m_w)) & 32'hFF);
                    m_by     = int'((base_y >> (7 * m_w)) & 28'h7F);
                end
            end else if (m_t == SVC) begin
                m_ptr    = m_w;
                m_active = 1'b0;
            end else begin
                m_t++;
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0, plot_cnt = 0, plot1_cnt = 0, grant_cyc_cnt = 0, done_cnt = 0;
    int done_cyc = 0, grant_rise = 0, last_x = 0, last_y = 0;
    int done_bit [4] = '{0, 0, 0, 0};
    logic [3:0] prev_g = '0;
    int gq[$];

    always @(negedge clock) begin
        cyc++;
        if (plot0) begin plot_cnt++; last_x = int'(x0); last_y = int'(y0); end
        if (plot1) plot1_cnt++;
        if (grant0 != 0) grant_cyc_cnt++;
        if (done0 != 0) begin
            done_cnt++;
            done_cyc = cyc;
            for (int i = 0; i < 4; i++) if (done0[i]) done_bit[i]++;
        end
        if (grant0 != 0 && prev_g == 0) begin
            gq.push_back($clog2(grant0));
            grant_rise = cyc;
        end
        prev_g = grant0;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input string name, input int lim);
        int b = 0;
        while (done0 == 0 && b < lim) begin tick(); b++; end
        chk(name, int'(b < lim), 1);
    endtask

    int s_plot, s_plot1, s_gc, s_done, s_d1, b;

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        tick();
        chk("reset_lit", int'(|{grant0, done0, busy0, plot0, rom_addr0, x0, y0, colour0}), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single sprite at (12,6).
        base_x[7:0] = 8'd12; base_y[6:0] = 7'd6;
        s_plot = plot_cnt; s_plot1 = plot1_cnt; s_gc = grant_cyc_cnt; s_done = done_cnt;
        gq.delete();
        req = 4'b0001;
        b = 0;
        while (!plot0 && b < 10) begin tick(); b++; end
        chk("first_plot_seen", int'(b < 10), 1);
        chk("first_x", int'(x0), 12);
        chk("first_y", int'(y0), 6);
        wait_done("t1_done_seen", 2000);
        chk("t1_done_val", int'(done0), 1);
        req = 4'b0000;
        repeat (3) tick();
        chk("t1_grant_cycles", grant_cyc_cnt - s_gc, 1602);
        chk("t1_plots", plot_cnt - s_plot, 1600);
        chk("t1_last_x", last_x, 51);
        chk("t1_last_y", last_y, 45);
        chk("t1_done_cnt", done_cnt - s_done, 1);
        chk("t1_service", done_cyc - grant_rise, 1601);
        chk("transp_plots", plot1_cnt - s_plot1, 800);
        chk("t1_grants", gq.size(), 1);

        // All four requesting, from a fresh reset.
        reset_n = 1'b0; tick(); tick(); reset_n = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            base_x[8*i +: 8] = 8'(i * 30);
            base_y[7*i +: 7] = 7'(i * 20);
        end
        gq.delete(); s_done = done_cnt;
        req = 4'b1111;
        b = 0;
        while (gq.size() < 5 && b < 5 * SVC + 50) begin tick(); b++; end
        chk("rr_seen5", int'(b < 5 * SVC + 50), 1);
        for (int i = 0; i < 5; i++) chk("rr_order", (i < gq.size()) ? gq[i] : -1, i % 4);
        chk("rr_dones", done_cnt - s_done, 4);

        // Reset in the middle of sprite 2.
        b = 0;
        while (!(grant0 == 4'b0100 && rom_addr0 == 11'd500) && b < 4000) begin tick(); b++; end
        chk("mid_seen", int'(b < 4000), 1);
        s_done = done_cnt;
        #1 reset_n = 1'b0;
        #1 chk("reset_async", int'(|{grant0, done0, busy0, plot0, rom_addr0, x0, y0, colour0}), 0);
        gq.delete();
        @(posedge clock); @(posedge clock); #1 reset_n = 1'b1;
        b = 0;
        while (gq.size() < 1 && b < 10) begin tick(); b++; end
        chk("post_reset_seen", int'(b < 10), 1);
        chk("post_reset_winner", (gq.size() > 0) ? gq[0] : -1, 0);
        chk("no_done_on_reset", done_cnt - s_done, 0);
        wait_done("pr_done_seen", 2000);
        req = 4'b0000;
        repeat (3) tick();

        // Clipping at (150,100).
        base_x[7:0] = 8'd150; base_y[6:0] = 7'd100;
        s_plot = plot_cnt;
        req = 4'b0001;
        tick();
        wait_done("clip_done_seen", 2000);
        req = 4'b0000;
        repeat (3) tick();
        chk("clip_plots", plot_cnt - s_plot, 200);
        chk("clip_service", done_cyc - grant_rise, 1601);

        // Drop req[1] mid-draw; also move its base, which must be ignored.
        base_x[7:0] = 8'd0; base_y[6:0] = 7'd0;
        base_x[15:8] = 8'd20; base_y[13:7] = 7'd30;
        gq.delete(); s_d1 = done_bit[1];
        req = 4'b0011;
        b = 0;
        while (!(grant0 == 4'b0010 && rom_addr0 == 11'd700) && b < 2000) begin tick(); b++; end
        chk("drop_seen", int'(b < 2000), 1);
        req = 4'b0001;
        base_x[15:8] = 8'd99;
        b = 0;
        while (gq.size() < 2 && b < 2000) begin tick(); b++; end
        chk("drop_next_seen", int'(b < 2000), 1);
        chk("drop_first", (gq.size() > 0) ? gq[0] : -1, 1);
        chk("drop_second", (gq.size() > 1) ? gq[1] : -1, 0);
        chk("drop_done1", done_bit[1] - s_d1, 1);
        wait_done("drop_done0_seen", 2000);
        req = 4'b0000;
        repeat (20) tick();
        chk("drop_no_regrant", gq.size(), 2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
